// File: rtl/branch_tag_allocator_pkg.sv
// Shared sizes and mask types for the dispatch-stage branch tag allocator.
package branch_tag_allocator_pkg;

  localparam int B_MASK_WIDTH   = 4;
  localparam int DISPATCH_WIDTH = 3;
  localparam int DISP_CNT_W     = $clog2(DISPATCH_WIDTH + 1);
  localparam int FREE_CNT_W     = $clog2(B_MASK_WIDTH + 1);

  typedef logic [B_MASK_WIDTH-1:0] B_MASK;
  typedef logic [DISP_CNT_W-1:0]   DISP_CNT;
  typedef logic [FREE_CNT_W-1:0]   FREE_CNT;

  function automatic FREE_CNT count_ones(input B_MASK m);
    FREE_CNT n;
    n = '0;
    for (int i = 0; i < B_MASK_WIDTH; i++) begin
      if (m[i]) n = n + FREE_CNT'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_tag_allocator_tag_psel.sv
// Lowest-index-first priority selector: one-hot grant of the lowest set request bit.
module tag_psel
  import branch_tag_allocator_pkg::*;
(
  input  B_MASK req,
  output B_MASK gnt
);

  assign gnt = req & (~req + B_MASK'(1));

endmodule

// File: rtl/branch_tag_allocator.sv
// Hands out one-hot branch tags at dispatch and tracks per-tag older-branch
// dependencies so a mispredict frees every younger tag.
module branch_tag_allocator
  import branch_tag_allocator_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  logic    [DISPATCH_WIDTH-1:0]        disp_valid,
  input  logic    [DISPATCH_WIDTH-1:0]        disp_is_branch,
  input  DISP_CNT                             disp_limit,
  input  B_MASK                               b_mm_resolve,
  input  logic                                b_mm_mispred,
  output DISP_CNT                             disp_accept_cnt,
  output B_MASK   [DISPATCH_WIDTH-1:0]        slot_b_mask,
  output B_MASK   [DISPATCH_WIDTH-1:0]        slot_b_tag,
  output B_MASK                               next_b_mask,
  output FREE_CNT                             free_tag_cnt
);

  // Handshake: slots 0..disp_accept_cnt-1 are consumed this cycle; the rest
  // were not taken and must be presented again (acceptance never leaves holes).

  B_MASK                     busy_q;
  B_MASK                     dep_q [B_MASK_WIDTH];
  B_MASK                     dep_d [B_MASK_WIDTH];
  B_MASK                     squash;
  B_MASK                     eff_busy;
  B_MASK                     free_mask;
  logic                      alloc_en;
  logic [DISPATCH_WIDTH-1:0] slot_ok;

  // A mispredict also kills every branch allocated while the bad one was in flight.
  always_comb begin
    squash = '0;
    for (int t = 0; t < B_MASK_WIDTH; t++) begin
      squash[t] = b_mm_mispred && ((dep_q[t] & b_mm_resolve) != '0);
    end
  end

  assign eff_busy  = busy_q & ~b_mm_resolve & ~squash;
  assign free_mask = ~eff_busy;
  assign alloc_en  = reset && !b_mm_mispred;

  // Each slot sees the free tags left over by the slots before it.
  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_slot
    B_MASK req;
    B_MASK gnt;
    B_MASK avail;
    logic  prev_ok;
    logic  ok;
    logic  take;

    if (k == 0) begin : g_head
      assign req     = free_mask;
      assign prev_ok = alloc_en;
    end else begin : g_link
      assign req     = g_slot[k-1].avail;
      assign prev_ok = g_slot[k-1].ok;
    end

    tag_psel u_psel (
      .req (req),
      .gnt (gnt)
    );

    assign ok    = prev_ok && (DISP_CNT'(k) < disp_limit) && disp_valid[k] &&
                   (!disp_is_branch[k] || (req != '0));
    assign take  = ok && disp_is_branch[k];
    assign avail = take ? (req & ~gnt) : req;

    assign slot_b_tag[k]  = take ? gnt : '0;
    assign slot_b_mask[k] = ok ? ~req : '0;
    assign slot_ok[k]     = ok;
  end

  always_comb begin
    disp_accept_cnt = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (slot_ok[k]) disp_accept_cnt = disp_accept_cnt + DISP_CNT'(1);
    end
  end

  assign next_b_mask  = reset ? ~g_slot[DISPATCH_WIDTH-1].avail : '0;
  assign free_tag_cnt = count_ones(~busy_q);

  // Surviving tags drop resolved ancestors; dead tags forget everything.
  always_comb begin
    for (int t = 0; t < B_MASK_WIDTH; t++) begin
      dep_d[t] = eff_busy[t] ? (dep_q[t] & ~b_mm_resolve) : '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (slot_b_tag[k][t]) dep_d[t] = slot_b_mask[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      for (int t = 0; t < B_MASK_WIDTH; t++) dep_q[t] <= '0;
    end else begin
      busy_q <= next_b_mask;
      for (int t = 0; t < B_MASK_WIDTH; t++) dep_q[t] <= dep_d[t];
    end
  end

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Table-driven bench for branch_tag_allocator with an expected-output queue.
module tb_branch_tag_allocator;
  import branch_tag_allocator_pkg::*;

  localparam int EXP_W = DISP_CNT_W + 2 * DISPATCH_WIDTH * B_MASK_WIDTH + B_MASK_WIDTH + FREE_CNT_W;

  typedef struct packed {
    logic [DISPATCH_WIDTH-1:0]  valid;
    logic [DISPATCH_WIDTH-1:0]  branch;
    DISP_CNT                    limit;
    B_MASK                      resolve;
    logic                       mispred;
    DISP_CNT                    cnt;
    B_MASK [DISPATCH_WIDTH-1:0] tag;
    B_MASK [DISPATCH_WIDTH-1:0] mask;
    B_MASK                      next;
    FREE_CNT                    free;
  } vec_t;

  logic                       clock;
  logic                       reset;
  logic [DISPATCH_WIDTH-1:0]  disp_valid;
  logic [DISPATCH_WIDTH-1:0]  disp_is_branch;
  DISP_CNT                    disp_limit;
  B_MASK                      b_mm_resolve;
  logic                       b_mm_mispred;
  DISP_CNT                    disp_accept_cnt;
  B_MASK [DISPATCH_WIDTH-1:0] slot_b_mask;
  B_MASK [DISPATCH_WIDTH-1:0] slot_b_tag;
  B_MASK                      next_b_mask;
  FREE_CNT                    free_tag_cnt;

  logic [EXP_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  vec_t vecs[13];

  branch_tag_allocator dut (
    .clock           (clock),
    .reset           (reset),
    .disp_valid      (disp_valid),
    .disp_is_branch  (disp_is_branch),
    .disp_limit      (disp_limit),
    .b_mm_resolve    (b_mm_resolve),
    .b_mm_mispred    (b_mm_mispred),
    .disp_accept_cnt (disp_accept_cnt),
    .slot_b_mask     (slot_b_mask),
    .slot_b_tag      (slot_b_tag),
    .next_b_mask     (next_b_mask),
    .free_tag_cnt    (free_tag_cnt)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // protocol and invariant assertions
  always @(posedge clock) begin
    B_MASK seen;
    seen = '0;
    if (reset) begin
      if (b_mm_mispred)
        assert ($onehot(b_mm_resolve)) else $error("mispredict with non-one-hot resolve %b", b_mm_resolve);
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        assert ($onehot0(slot_b_tag[k])) else $error("slot %0d tag not one-hot: %b", k, slot_b_tag[k]);
        assert ((slot_b_tag[k] & seen) == '0) else $error("slot %0d tag reused: %b", k, slot_b_tag[k]);
        assert ((slot_b_tag[k] & dut.busy_q & ~b_mm_resolve) == '0)
          else $error("slot %0d granted busy tag %b", k, slot_b_tag[k]);
        seen = seen | slot_b_tag[k];
      end
    end
    for (int t = 0; t < B_MASK_WIDTH; t++)
      assert (!dut.dep_q[t][t]) else $error("tag %0d depends on itself", t);
  end

  function automatic vec_t mk(input logic [2:0] va, input logic [2:0] br, input DISP_CNT li,
                              input B_MASK rs, input logic mp, input DISP_CNT c,
                              input B_MASK t0, input B_MASK t1, input B_MASK t2,
                              input B_MASK m0, input B_MASK m1, input B_MASK m2,
                              input B_MASK nx, input FREE_CNT fr);
    vec_t v;
    v.valid = va;  v.branch = br;  v.limit = li;  v.resolve = rs;  v.mispred = mp;
    v.cnt = c;
    v.tag[0] = t0;   v.tag[1] = t1;   v.tag[2] = t2;
    v.mask[0] = m0;  v.mask[1] = m1;  v.mask[2] = m2;
    v.next = nx;  v.free = fr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver: apply inputs and record the expected outputs
  task automatic apply_vec(input vec_t v);
    disp_valid     = v.valid;
    disp_is_branch = v.branch;
    disp_limit     = v.limit;
    b_mm_resolve   = v.resolve;
    b_mm_mispred   = v.mispred;
    exp_q.push_back({v.cnt, v.tag, v.mask, v.next, v.free});
  endtask

  // scoreboard: pop one expected record and compare against the DUT
  task automatic check_out(input string tag);
    logic [EXP_W-1:0]           e;
    DISP_CNT                    e_cnt;
    B_MASK [DISPATCH_WIDTH-1:0] e_tag;
    B_MASK [DISPATCH_WIDTH-1:0] e_mask;
    B_MASK                      e_next;
    FREE_CNT                    e_free;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got output with no expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    {e_cnt, e_tag, e_mask, e_next, e_free} = e;
    check({tag, ".accept"}, 32'(disp_accept_cnt), 32'(e_cnt));
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      check($sformatf("%s.tag%0d", tag, k), 32'(slot_b_tag[k]), 32'(e_tag[k]));
      check($sformatf("%s.mask%0d", tag, k), 32'(slot_b_mask[k]), 32'(e_mask[k]));
    end
    check({tag, ".next"}, 32'(next_b_mask), 32'(e_next));
    check({tag, ".free"}, 32'(free_tag_cnt), 32'(e_free));
  endtask

  task automatic drive(input vec_t v, input string tag);
    @(negedge clock);
    apply_vec(v);
    #1;
    check_out(tag);
  endtask

  initial begin
    reset = 1'b0;
    apply_vec(mk(3'b000, 3'b000, 2'd0, 4'b0000, 1'b0, 2'd0, '0, '0, '0, '0, '0, '0, '0, 3'd4));
    exp_q.delete();

    //            valid   branch  lim  resolve  mp   cnt  tag0     tag1     tag2     mask0    mask1    mask2    next     free
    vecs[0]  = mk(3'b111, 3'b010, 2'd3, 4'b0000, 1'b0, 2'd3, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 3'd4);
    vecs[1]  = mk(3'b111, 3'b011, 2'd3, 4'b0000, 1'b0, 2'd3, 4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0111, 3'd3);
    vecs[2]  = mk(3'b111, 3'b111, 2'd3, 4'b0000, 1'b0, 2'd1, 4'b1000, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b1111, 3'd1);
    vecs[3]  = mk(3'b111, 3'b100, 2'd3, 4'b0000, 1'b0, 2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 3'd0);
    vecs[4]  = mk(3'b001, 3'b001, 2'd3, 4'b1000, 1'b0, 2'd1, 4'b1000, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b1111, 3'd0);
    vecs[5]  = mk(3'b111, 3'b000, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 3'd0);
    vecs[6]  = mk(3'b111, 3'b001, 2'd3, 4'b0010, 1'b1, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 3'd0);
    vecs[7]  = mk(3'b001, 3'b001, 2'd3, 4'b0000, 1'b0, 2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 3'd3);
    vecs[8]  = mk(3'b111, 3'b110, 2'd3, 4'b0001, 1'b0, 2'd3, 4'b0000, 4'b0001, 4'b0100, 4'b0010, 4'b0010, 4'b0011, 4'b0111, 3'd2);
    vecs[9]  = mk(3'b101, 3'b000, 2'd3, 4'b1100, 1'b0, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 3'd1);
    vecs[10] = mk(3'b111, 3'b111, 2'd3, 4'b0001, 1'b1, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 3'd2);
    vecs[11] = mk(3'b111, 3'b111, 2'd2, 4'b0000, 1'b0, 2'd2, 4'b0001, 4'b0100, 4'b0000, 4'b0010, 4'b0011, 4'b0000, 4'b0111, 3'd3);
    vecs[12] = mk(3'b111, 3'b111, 2'd3, 4'b0000, 1'b0, 2'd1, 4'b1000, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b1111, 3'd1);

    // reset state, with a full bundle presented while reset is held
    drive(mk(3'b111, 3'b111, 2'd3, 4'b0000, 1'b0, 2'd0, '0, '0, '0, '0, '0, '0, 4'b0000, 3'd4), "reset");
    apply_vec(mk(3'b000, 3'b000, 2'd0, 4'b0000, 1'b0, 2'd0, '0, '0, '0, '0, '0, '0, '0, 3'd0));
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) drive(vecs[i], $sformatf("vec%0d", i));

    // dependency bookkeeping after the correct resolve and later mispredict
    @(negedge clock);
    check("dep_tag1", 32'(dut.dep_q[1]), 32'(4'b0000));
    check("dep_tag3", 32'(dut.dep_q[3]), 32'(4'b0111));

    // asynchronous reset mid-bundle with every tag busy
    reset = 1'b0;
    apply_vec(mk(3'b111, 3'b111, 2'd3, 4'b0000, 1'b0, 2'd0, '0, '0, '0, '0, '0, '0, 4'b0000, 3'd4));
    #1;
    check_out("midreset");

    @(negedge clock);
    reset = 1'b1;
    apply_vec(mk(3'b001, 3'b001, 2'd3, 4'b0000, 1'b0, 2'd1, 4'b0001, '0, '0, '0, '0, '0, 4'b0001, 3'd4));
    #1;
    check_out("post_reset");
    drive(mk(3'b000, 3'b000, 2'd3, 4'b0000, 1'b0, 2'd0, '0, '0, '0, '0, '0, '0, 4'b0001, 3'd3), "idle");

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
